led_serial_tx: RTL
==================

Name: led_serial_tx

Overview:
- Transmit end of the LED driver serial data link: it produces the DCK/DAI/DEN stream that the LED display driver deserialises into its 512x16 frame SRAM.
- Accepts 16-bit grey-scale pixel words through a valid/ready handshake and shifts each word out one bit per DCK cycle with DEN high.
- After each word it inserts DEN-low gap cycles; the receiver commits a word to SRAM during DEN-low.
- Counts pixels per frame, pulses frame_done at each frame boundary, and raises Vsync after the first complete frame.

Parameters:
- PIX_W, 16, pixel word width (bits per serial word).
- PIX_PER_FRAME, 512, pixels per frame (32 scanlines x 16 channels).
- GAP, 1, DEN-low cycles after each word. Values below 1 are treated as 1.

Ports:
- DCK  in  1  sole clock; all outputs change on posedge DCK.
- rst  in  1  synchronous, active-high reset.
- pix_data  in  PIX_W  pixel word; sampled on the handshake cycle.
- pix_valid  in  1  upstream has a word.
- pix_ready  out  1  block can accept a word this cycle.
- frame_restart  in  1  one-cycle request to restart the pixel count at 0.
- DAI  out  1  serial data bit.
- DEN  out  1  data enable; high only while bits are shifted.
- Vsync  out  1  high once the first full frame has been sent; sticky.
- pix_index  out  9  index of the next pixel to be accepted (0..PIX_PER_FRAME-1).
- frame_done  out  1  one-cycle pulse when the last pixel of a frame finishes its gap.
- busy  out  1  high in SHIFT or GAP.

Behaviour:
- Interface: one clock (DCK); reset is synchronous and active-high (rst).
- Reset values: all outputs 0 except pix_ready=1. State=IDLE, shift register=0, bit counter=0, gap counter=0, pixel counter=0, restart pending=0.
- State machine:
  - IDLE: pix_ready=1. On pix_valid & pix_ready, load the shift register from pix_data and go to SHIFT.
  - SHIFT: runs 16 cycles; DEN=1; DAI=current bit. Bit counter counts 0..15. After bit 15, go to GAP.
  - GAP: runs GAP cycles; DEN=0; DAI=0. pix_ready=1 only in the final GAP cycle.
    - If a word is accepted there, go directly to SHIFT.
    - Otherwise go to IDLE.
- Timing: a word accepted at cycle t gives DEN=1 on cycles t+1..t+16, with DAI=pix_data[i] at cycle t+1+i (LSB first). DEN=0 on cycles t+17..t+16+GAP.
- Throughput: back-to-back period is 16+GAP cycles per pixel.
- pix_data is don't-care when pix_ready=0. The handshake completes only when pix_valid and pix_ready are high together.
- Pixel counter:
  - Increments at the end of each word's final GAP cycle.
  - When it reaches PIX_PER_FRAME-1, that same cycle pulses frame_done for one cycle and the counter wraps to 0.
  - pix_index reflects the counter.
- Vsync: set on the first frame_done and held until rst.
- frame_restart:
  - In IDLE, with no handshake that cycle: the pixel counter clears to 0 on the next cycle.
  - Otherwise, including a handshake in the same cycle: the request is latched as pending and applied when that word's GAP ends, instead of the increment. No frame_done pulse is generated.
- Reset asserted during SHIFT or GAP aborts immediately: DEN falls the next cycle and the partial word is discarded.
- pix_valid may drop without a handshake. Nothing is committed until a handshake occurs.

Optional Feature:
- Macro: LEDTX_MSB_FIRST_EN.
- Defined: bit order is reversed; DAI=pix_data[15-i] at cycle t+1+i. Used for receivers that shift MSB first.
- Undefined: LSB first, as above; this is the production order for the LED driver.

Decomposition:
- Package led_link_pkg holds:
  - state enum (IDLE, SHIFT, GAP);
  - constants LED_PIX_W=16, LED_CH=16, LED_SCANLINES=32, LED_PIX_PER_FRAME=512.
- One sub-module, led_bit_serializer: the PIX_W shift register plus bit counter. It has load/shift inputs, produces DAI, and flags last_bit.
- FSM, gap counter and pixel/frame counters live in the top-level module.

Test Plan:
- Single word 16'hA5C3, GAP=1: DEN high exactly 16 cycles; DAI sequence 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1; then one DEN-low cycle; pix_index 0->1.
- Continuous pix_valid, GAP=1, 3 words: each DEN burst starts 17 cycles after the previous; pix_ready high only in IDLE or final GAP cycles.
- Full frame of 512 words (value = index): frame_done pulses once after word 511's gap; pix_index wraps to 0; Vsync rises that cycle and stays high through a second frame.
- frame_restart asserted mid-SHIFT at pix_index=37: current word completes, pix_index becomes 0 (not 38), no frame_done.
- rst asserted at bit 7 of word 16'hFFFF: next cycle DEN=0, DAI=0, pix_ready=1, pix_index=0, Vsync=0.
- LEDTX_MSB_FIRST_EN build, word 16'h8001: DAI=1 on the first and sixteenth DEN cycles, 0 otherwise; word 16'h0003 gives DAI=1 on cycles 15 and 16 only.

Source files
------------

// File: rtl/led_serial_tx_pkg.sv
// Shared types and geometry of the LED driver serial link.
package led_link_pkg;

  typedef enum logic [1:0] {
    LED_IDLE  = 2'd0,
    LED_SHIFT = 2'd1,
    LED_GAP   = 2'd2
  } led_state_e;

  localparam int LED_PIX_W         = 16;
  localparam int LED_CH            = 16;
  localparam int LED_SCANLINES     = 32;
  localparam int LED_PIX_PER_FRAME = LED_CH * LED_SCANLINES;

  // The receiver needs at least one DEN-low cycle to commit a word.
  function automatic int led_gap_eff(input int gap);
    return (gap < 1) ? 1 : gap;
  endfunction

endpackage

// File: rtl/led_serial_tx_if.sv
// Pixel-word valid/ready handshake between the frame source and the transmitter.
interface led_serial_tx_if
  import led_link_pkg::*;
#(
  parameter int PIX_W = LED_PIX_W
) ();
  logic [PIX_W-1:0] pix_data;
  logic             pix_valid;
  logic             pix_ready;

  modport master (output pix_data, output pix_valid, input pix_ready);
  modport slave  (input pix_data, input pix_valid, output pix_ready);
endinterface

// File: rtl/led_serial_tx_bit_serializer.sv
// Shift register and bit counter for one pixel word; DAI comes straight off a flop.
// LEDTX_MSB_FIRST_EN selects MSB-first order; LSB first when undefined.
module led_bit_serializer #(
  parameter int PIX_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [PIX_W-1:0] data,
  output logic             dai,
  output logic             last_bit
);
  localparam int            BW   = $clog2(PIX_W);
  localparam logic [BW-1:0] LAST = BW'(PIX_W - 1);

  logic [PIX_W-1:0] sr_q, sr_d;
  logic [BW-1:0]    cnt_q, cnt_d;

  // Zeros are shifted in so DAI rests at 0 once the word has gone out.
  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (load) begin
      sr_d  = data;
      cnt_d = '0;
    end else if (shift) begin
`ifdef LEDTX_MSB_FIRST_EN
      sr_d  = {sr_q[PIX_W-2:0], 1'b0};
`else
      sr_d  = {1'b0, sr_q[PIX_W-1:1]};
`endif
      cnt_d = cnt_q + 1'b1;
    end else begin
      sr_d  = sr_q;
      cnt_d = cnt_q;
    end
  end

  // Shift register and bit counter state.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

`ifdef LEDTX_MSB_FIRST_EN
  assign dai = sr_q[PIX_W-1];
`else
  assign dai = sr_q[0];
`endif
  assign last_bit = (cnt_q == LAST);

endmodule

// File: rtl/led_serial_tx.sv
// LED serial link transmitter: word FSM, DEN-low gap timing, pixel/frame counters.
// Bit order is chosen inside led_bit_serializer by LEDTX_MSB_FIRST_EN.
module led_serial_tx
  import led_link_pkg::*;
#(
  parameter int PIX_W         = LED_PIX_W,
  parameter int PIX_PER_FRAME = LED_PIX_PER_FRAME,
  parameter int GAP           = 1
) (
  input  logic           DCK,
  input  logic           rst,
  led_serial_tx_if.slave pix_if,
  input  logic           frame_restart,
  output logic           DAI,
  output logic           DEN,
  output logic           Vsync,
  output logic [8:0]     pix_index,
  output logic           frame_done,
  output logic           busy
);
  localparam logic [1:0] IDLE  = LED_IDLE;
  localparam logic [1:0] SHIFT = LED_SHIFT;
  localparam logic [1:0] GAPS  = LED_GAP;

  localparam int            GAP_EFF  = led_gap_eff(GAP);
  localparam int            GW       = (GAP_EFF > 1) ? $clog2(GAP_EFF) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_EFF - 1);
  localparam logic [8:0]    LAST_PIX = 9'(PIX_PER_FRAME - 1);

  logic [1:0]    state_q, state_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic [8:0]    pix_cnt_q, pix_cnt_d;
  logic          pend_q, pend_d;
  logic          vsync_q, vsync_d;
  logic          fd_q, fd_d;
  logic          den_q, den_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;

  logic hs, load, shift, last_bit, word_end, restart_idle, restart_defer;

  assign hs            = pix_if.pix_valid & ready_q;
  assign word_end      = (state_q == GAPS) && (gap_cnt_q == GAP_LAST);
  assign restart_idle  = frame_restart & (state_q == IDLE) & ~hs;
  assign restart_defer = frame_restart & ~restart_idle;

  led_bit_serializer #(.PIX_W(PIX_W)) u_ser (
    .clk      (DCK),
    .rst      (rst),
    .load     (load),
    .shift    (shift),
    .data     (pix_if.pix_data),
    .dai      (DAI),
    .last_bit (last_bit)
  );

  // Word sequencing; a word accepted in the last gap cycle starts shifting at once.
  always_comb begin
    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    load      = 1'b0;
    shift     = 1'b0;
    case (state_q)
      IDLE: begin
        if (hs) begin
          load    = 1'b1;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        shift = 1'b1;
        if (last_bit) begin
          state_d   = GAPS;
          gap_cnt_d = '0;
        end else begin
          state_d = SHIFT;
        end
      end
      GAPS: begin
        if (word_end) begin
          gap_cnt_d = '0;
          if (hs) begin
            load    = 1'b1;
            state_d = SHIFT;
          end else begin
            state_d = IDLE;
          end
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d   = IDLE;
        gap_cnt_d = '0;
      end
    endcase
  end

  // Pixel/frame accounting; a deferred restart replaces the increment and its frame_done.
  always_comb begin
    pix_cnt_d = pix_cnt_q;
    fd_d      = 1'b0;
    vsync_d   = vsync_q;
    if (restart_idle) begin
      pix_cnt_d = '0;
    end else if (word_end && pend_q) begin
      pix_cnt_d = '0;
    end else if (word_end && (pix_cnt_q == LAST_PIX)) begin
      pix_cnt_d = '0;
      fd_d      = 1'b1;
      vsync_d   = 1'b1;
    end else if (word_end) begin
      pix_cnt_d = pix_cnt_q + 9'd1;
    end else begin
      pix_cnt_d = pix_cnt_q;
    end

    if (restart_defer) begin
      pend_d = 1'b1;
    end else if (restart_idle || word_end) begin
      pend_d = 1'b0;
    end else begin
      pend_d = pend_q;
    end
  end

  // Output decode from the next state so every output leaves a flop.
  always_comb begin
    den_d   = (state_d == SHIFT);
    busy_d  = (state_d != IDLE);
    ready_d = (state_d == IDLE) || ((state_d == GAPS) && (gap_cnt_d == GAP_LAST));
  end

  // State and output registers.
  always_ff @(posedge DCK) begin
    if (rst) begin
      state_q   <= IDLE;
      gap_cnt_q <= '0;
      pix_cnt_q <= '0;
      pend_q    <= 1'b0;
      vsync_q   <= 1'b0;
      fd_q      <= 1'b0;
      den_q     <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      gap_cnt_q <= gap_cnt_d;
      pix_cnt_q <= pix_cnt_d;
      pend_q    <= pend_d;
      vsync_q   <= vsync_d;
      fd_q      <= fd_d;
      den_q     <= den_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
    end
  end

  assign pix_if.pix_ready = ready_q;
  assign DEN              = den_q;
  assign busy             = busy_q;
  assign Vsync            = vsync_q;
  assign frame_done       = fd_q;
  assign pix_index        = pix_cnt_q;

endmodule
